cdc_fifo_src_arbiter: RTL and testbench
=======================================

Name: cdc_fifo_src_arbiter

Overview:
- Shares the source port of one cdc_fifo_2phase between NumInp single-clock requesters in the FIFO's source domain.
- Round-robin arbitration with burst locking. A granted requester keeps the FIFO until it presents a beat with last set.
- Emits the winner index alongside the data so the destination side can demultiplex.
- Sits directly in front of the CDC FIFO: oup_* drives src_data_i/src_valid_i, and oup_ready_i is driven by src_ready_o.

Parameters:
- NumInp, 4, number of requesters; must be at least 2.
- DataWidth, 32, payload width per beat.
- MaxBurst, 16, maximum beats per burst before err_o is raised; 0 disables the check.
- IdxWidth, derived as $clog2(NumInp), width of oup_idx_o.

Ports:
- clk_i  in  1  clock; identical to the FIFO's src_clk_i.
- rst_ni  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous clear; same effect as reset.
- inp_data_i  in  NumInp x DataWidth  per-requester payload.
- inp_last_i  in  NumInp  per-requester end-of-burst flag.
- inp_valid_i  in  NumInp  per-requester valid.
- inp_ready_o  out  NumInp  per-requester ready.
- oup_data_o  out  DataWidth  payload to the FIFO.
- oup_idx_o  out  IdxWidth  index of the granted requester.
- oup_last_o  out  1  last flag of the current beat.
- oup_valid_o  out  1  valid to the FIFO.
- oup_ready_i  in  1  ready from the FIFO (src_ready_o).
- busy_o  out  1  high when the FSM is not in IDLE.
- err_o  out  1  sticky flag: a burst exceeded MaxBurst beats.

Behaviour:
- Reset or clr_i gives:
  - state=IDLE, rr_ptr=0, beat_cnt=0, err_o=0.
  - All outputs 0 except oup_data_o, which muxes input 0 (don't-care while invalid).
- Datapath is combinational and zero-latency: oup_data/last/idx come from the granted input; no data is registered.
- Grant selection:
  - IDLE: winner = first index i ≥ rr_ptr (wrapping modulo NumInp) with inp_valid_i[i].
  - HOLD and BURST: the grant is the registered lock_idx; no re-arbitration.
- Handshake: oup_valid_o = inp_valid_i[grant]; inp_ready_o[grant] = oup_ready_i; all other inp_ready_o are 0. A transfer occurs when oup_valid_o && oup_ready_i.
- AXI-style stability: once oup_valid_o is high and not accepted, the grant does not change. Requesters must hold valid and data stable; the block does not check this.
- FSM transitions:
  - IDLE, some valid, transfer with last=1: stay IDLE; rr_ptr = winner+1 (mod NumInp).
  - IDLE, some valid, transfer with last=0: go to BURST; lock_idx=winner; beat_cnt=1.
  - IDLE, some valid, no transfer: go to HOLD; lock_idx=winner.
  - HOLD, transfer with last=1: go to IDLE; rr_ptr=lock_idx+1.
  - HOLD, transfer with last=0: go to BURST; beat_cnt=1.
  - HOLD, no transfer: stay in HOLD.
  - BURST, transfer with last=0: beat_cnt++, saturating at 2^$clog2(MaxBurst+1)-1.
  - BURST, transfer with last=1: go to IDLE; rr_ptr=lock_idx+1; beat_cnt=0.
  - BURST, requester drops valid: stay in BURST; the lock holds.
- err_o: set when a transfer with last=0 occurs while beat_cnt+1 ≥ MaxBurst (with MaxBurst≠0). It stays set until reset or clr_i. Arbitration is not affected.
- busy_o = (state != IDLE).
- rr_ptr wraps: NumInp-1 + 1 gives 0. For NumInp not a power of two, use explicit compare-and-wrap, never bit truncation.
- clr_i mid-burst: the lock is dropped immediately and the next cycle behaves as after reset. Clearing the FIFO (its src_clr_i) at the same time is the integrator's responsibility.
- clr_i and a transfer in the same cycle: the transfer handshake completes combinationally, and clr_i wins for all state updates.

Decomposition:
- Package cdc_fifo_arb_pkg holds:
  - typedef arb_state_e {IDLE, HOLD, BURST}, 2-bit.
  - A function rr_next(idx, n) returning the wrapped increment.
- Sub-module rr_pick: combinational first-set-at-or-after-pointer search.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, idx.
- The top module holds the FSM, the lock/beat/err registers and the output muxing.

Test Plan:
- Single beats, all four valid, last=1, ready=1 constantly -> grants 0,1,2,3,0 on consecutive cycles; oup_idx_o matches; busy_o stays 0.
- Burst lock: req1 sends 3 beats (last on the 3rd) while req2 is valid -> oup_idx_o=1 for all 3 beats; req2 is granted in the next cycle; inp_ready_o[2]=0 during the burst.
- Backpressure: oup_ready_i=0 for 5 cycles with req0 valid, then req3 also becomes valid -> state HOLD; oup_idx_o stays 0 throughout; after ready rises, req0 transfers first.
- Wrap and skip: rr_ptr=3 with only req1 valid -> req1 is granted; after last, rr_ptr=2. Then req0 and req3 become valid -> req3 is granted before req0.
- MaxBurst=4: req2 sends 5 beats without last -> err_o rises on the 4th transfer and stays high. clr_i -> err_o=0, state=IDLE, rr_ptr=0.
- Async reset asserted mid-burst (state BURST, beat_cnt=2) -> all outputs drop immediately; after release, arbitration restarts at index 0.

Source files
------------

// File: rtl/cdc_fifo_arb_pkg.sv
// Shared types and helpers for cdc_fifo_src_arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, HOLD, BURST).
//   rr_next     : round-robin pointer increment with explicit wrap. It works
//                 for requester counts that are not a power of two.
package cdc_fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    // Compare-and-wrap rather than truncating to the index width, because
    // truncation would land on invalid indices when n is not a power of two.
    function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: finds the first set bit of req_i at or
// after ptr_i, wrapping modulo NumInp.
//   req_i : request vector
//   ptr_i : search start index (always < NumInp)
//   any_o : at least one request is set
//   idx_o : index of the winning request (0 when any_o is low)
module rr_pick #(
    parameter int unsigned NumInp   = 4,
    parameter int unsigned IdxWidth = $clog2(NumInp)
) (
    input  logic [NumInp-1:0]   req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic                any_o,
    output logic [IdxWidth-1:0] idx_o
);

    logic [IdxWidth:0]   sum;
    logic [IdxWidth-1:0] cand;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < int'(NumInp); k++) begin
            // One extra bit so ptr+k cannot overflow before the wrap compare.
            sum = {1'b0, ptr_i} + (IdxWidth+1)'(k);
            if (sum >= (IdxWidth+1)'(NumInp)) begin
                sum = sum - (IdxWidth+1)'(NumInp);
            end
            cand = sum[IdxWidth-1:0];
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/cdc_fifo_src_arbiter.sv
// Round-robin arbiter with burst locking. It shares the source port of a
// cdc_fifo_2phase between NumInp requesters in the FIFO's source clock domain.
// The datapath is purely combinational. The winner index travels with the
// data so that the destination side can demultiplex.
//   clk_i, rst_ni, clr_i       : clock, async active-low reset, sync clear
//   inp_data/last/valid_i      : per-requester beat
//   inp_ready_o                : per-requester ready (only the grant can be 1)
//   oup_data/idx/last/valid_o  : beat towards the FIFO's src_* port
//   oup_ready_i                : FIFO src_ready_o
//   busy_o                     : FSM not in IDLE
//   err_o                      : sticky, a burst ran past MaxBurst beats
module cdc_fifo_src_arbiter
    import cdc_fifo_arb_pkg::*;
#(
    parameter int unsigned NumInp    = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxBurst  = 16,
    parameter int unsigned IdxWidth  = $clog2(NumInp)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clr_i,
    input  logic [NumInp-1:0][DataWidth-1:0] inp_data_i,
    input  logic [NumInp-1:0]                inp_last_i,
    input  logic [NumInp-1:0]                inp_valid_i,
    output logic [NumInp-1:0]                inp_ready_o,
    output logic [DataWidth-1:0]             oup_data_o,
    output logic [IdxWidth-1:0]              oup_idx_o,
    output logic                             oup_last_o,
    output logic                             oup_valid_o,
    input  logic                             oup_ready_i,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int unsigned CntWidth = (MaxBurst == 0) ? 1 : $clog2(MaxBurst + 1);
    localparam logic [CntWidth-1:0] CntMax = '1;

    arb_state_e          state_q, state_d;
    logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
    logic [CntWidth-1:0] beat_cnt_q, beat_cnt_d;
    logic                err_q, err_d;

    logic                pick_any;
    logic [IdxWidth-1:0] pick_idx;
    logic [IdxWidth-1:0] grant_idx;
    logic                xfer;

    rr_pick #(
        .NumInp  (NumInp),
        .IdxWidth(IdxWidth)
    ) u_rr_pick (
        .req_i(inp_valid_i),
        .ptr_i(rr_ptr_q),
        .any_o(pick_any),
        .idx_o(pick_idx)
    );

    // While reset is asserted the grant is forced to 0 and the handshake is
    // masked. This keeps the FIFO from seeing a beat during reset even if a
    // requester is still driving valid.
    always_comb begin
        grant_idx = '0;
        if (rst_ni) begin
            grant_idx = (state_q == IDLE) ? pick_idx : lock_idx_q;
        end
    end

    always_comb begin
        inp_ready_o = '0;
        if (rst_ni) begin
            inp_ready_o[grant_idx] = oup_ready_i;
        end
    end

    assign oup_data_o  = inp_data_i[grant_idx];
    assign oup_idx_o   = grant_idx;
    assign oup_last_o  = rst_ni & inp_last_i[grant_idx];
    assign oup_valid_o = rst_ni & inp_valid_i[grant_idx];
    assign xfer        = oup_valid_o & oup_ready_i;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;

        if (MaxBurst != 0 && xfer && !oup_last_o &&
            (32'(beat_cnt_q) + 32'd1) >= MaxBurst) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    lock_idx_d = pick_idx;
                    if (!xfer) begin
                        state_d = HOLD;
                    end else if (oup_last_o) begin
                        rr_ptr_d = IdxWidth'(rr_next(32'(pick_idx), NumInp));
                    end else begin
                        state_d    = BURST;
                        beat_cnt_d = CntWidth'(1);
                    end
                end
            end
            HOLD: begin
                if (xfer) begin
                    if (oup_last_o) begin
                        state_d    = IDLE;
                        rr_ptr_d   = IdxWidth'(rr_next(32'(lock_idx_q), NumInp));
                        beat_cnt_d = '0;
                    end else begin
                        state_d    = BURST;
                        beat_cnt_d = CntWidth'(1);
                    end
                end
            end
            BURST: begin
                // A requester dropping valid mid-burst keeps the lock.
                if (xfer) begin
                    if (oup_last_o) begin
                        state_d    = IDLE;
                        rr_ptr_d   = IdxWidth'(rr_next(32'(lock_idx_q), NumInp));
                        beat_cnt_d = '0;
                    end else if (beat_cnt_q != CntMax) begin
                        beat_cnt_d = beat_cnt_q + CntWidth'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear overrides every state update, including one from a beat
        // accepted in the same cycle.
        if (clr_i) begin
            state_d    = IDLE;
            rr_ptr_d   = '0;
            lock_idx_d = '0;
            beat_cnt_d = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Directed testbench for cdc_fifo_src_arbiter (NumInp=4, MaxBurst=4).
module tb_cdc_fifo_src_arbiter;

    localparam int NI = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic               clk = 1'b0;
    logic               rst_ni;
    logic               clr_i;
    logic [NI-1:0][DW-1:0] inp_data;
    logic [NI-1:0]      inp_last;
    logic [NI-1:0]      inp_valid;
    logic [NI-1:0]      inp_ready;
    logic [DW-1:0]      oup_data;
    logic [1:0]         oup_idx;
    logic               oup_last;
    logic               oup_valid;
    logic               oup_ready;
    logic               busy;
    logic               err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cdc_fifo_src_arbiter #(
        .NumInp   (NI),
        .DataWidth(DW),
        .MaxBurst (MB)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .inp_data_i (inp_data),
        .inp_last_i (inp_last),
        .inp_valid_i(inp_valid),
        .inp_ready_o(inp_ready),
        .oup_data_o (oup_data),
        .oup_idx_o  (oup_idx),
        .oup_last_o (oup_last),
        .oup_valid_o(oup_valid),
        .oup_ready_i(oup_ready),
        .busy_o     (busy),
        .err_o      (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni    = 1'b0;
        clr_i     = 1'b0;
        oup_ready = 1'b1;
        inp_last  = 4'b0000;
        inp_valid = 4'b0100;
        for (int i = 0; i < NI; i++) inp_data[i] = 32'hD000_0000 | i;
        tick();
        tick();
        checks++; if (oup_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", oup_valid); end
        checks++; if (inp_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b expected 0000", inp_ready); end
        checks++; if (oup_idx !== 2'd0) begin failures++; $display("FAIL reset_idx: got %0d expected 0", oup_idx); end
        checks++; if (busy !== 1'b0 || err !== 1'b0 || oup_last !== 1'b0) begin failures++; $display("FAIL reset_flags: busy=%0b err=%0b last=%0b expected 0", busy, err, oup_last); end
        checks++; if (oup_data !== 32'hD000_0000) begin failures++; $display("FAIL reset_data: got %h expected d0000000", oup_data); end
        inp_valid = 4'b0000;
        rst_ni    = 1'b1;
        tick();
    endtask

    task automatic test_single_beats();
        logic [1:0] exp;
        inp_valid = 4'b1111;
        inp_last  = 4'b1111;
        oup_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp = 2'(k % 4);
            checks++; if (oup_idx !== exp) begin failures++; $display("FAIL single_idx[%0d]: got %0d expected %0d", k, oup_idx, exp); end
            checks++; if (inp_ready !== 4'(1 << exp)) begin failures++; $display("FAIL single_ready[%0d]: got %b expected %b", k, inp_ready, 4'(1 << exp)); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy[%0d]: got %0b expected 0", k, busy); end
            checks++; if (oup_data !== (32'hD000_0000 | 32'(exp))) begin failures++; $display("FAIL single_data[%0d]: got %h expected %h", k, oup_data, 32'hD000_0000 | 32'(exp)); end
            tick();
        end
        inp_valid = 4'b0000;
    endtask

    // rr_ptr is 1 on entry.
    task automatic test_burst_lock();
        inp_valid = 4'b0110;
        inp_last  = 4'b0100;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) inp_last[1] = 1'b1;
            #1;
            checks++; if (oup_idx !== 2'd1) begin failures++; $display("FAIL burst_idx[%0d]: got %0d expected 1", b, oup_idx); end
            checks++; if (inp_ready !== 4'b0010) begin failures++; $display("FAIL burst_ready[%0d]: got %b expected 0010", b, inp_ready); end
            checks++; if (busy !== (b > 0)) begin failures++; $display("FAIL burst_busy[%0d]: got %0b expected %0b", b, busy, b > 0); end
            tick();
        end
        inp_valid[1] = 1'b0;
        inp_last[1]  = 1'b0;
        #1;
        checks++; if (oup_idx !== 2'd2 || inp_ready !== 4'b0100) begin failures++; $display("FAIL burst_next: idx=%0d ready=%b expected idx=2 ready=0100", oup_idx, inp_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_end_busy: got %0b expected 0", busy); end
        tick();
        inp_valid = 4'b0000;
    endtask

    // rr_ptr is 3 on entry; in IDLE req3 would win, so a held grant of 0 shows the lock.
    task automatic test_backpressure();
        oup_ready = 1'b0;
        inp_valid = 4'b0001;
        inp_last  = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (oup_idx !== 2'd0 || oup_valid !== 1'b1) begin failures++; $display("FAIL bp_hold[%0d]: idx=%0d valid=%0b expected idx=0 valid=1", c, oup_idx, oup_valid); end
            checks++; if (busy !== (c > 0)) begin failures++; $display("FAIL bp_busy[%0d]: got %0b expected %0b", c, busy, c > 0); end
            tick();
        end
        inp_valid = 4'b1001;
        inp_last  = 4'b1001;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (oup_idx !== 2'd0 || inp_ready !== 4'b0000) begin failures++; $display("FAIL bp_contend[%0d]: idx=%0d ready=%b expected idx=0 ready=0000", c, oup_idx, inp_ready); end
            tick();
        end
        oup_ready = 1'b1;
        #1;
        checks++; if (oup_idx !== 2'd0 || inp_ready !== 4'b0001) begin failures++; $display("FAIL bp_release: idx=%0d ready=%b expected idx=0 ready=0001", oup_idx, inp_ready); end
        tick();
        inp_valid = 4'b1000;
        #1;
        checks++; if (oup_idx !== 2'd3 || busy !== 1'b0) begin failures++; $display("FAIL bp_after: idx=%0d busy=%0b expected idx=3 busy=0", oup_idx, busy); end
        tick();
        inp_valid = 4'b0000;
    endtask

    // rr_ptr is 0 on entry.
    task automatic test_wrap_skip();
        inp_valid = 4'b0100;
        inp_last  = 4'b0100;
        #1;
        checks++; if (oup_idx !== 2'd2) begin failures++; $display("FAIL wrap_setup: got %0d expected 2", oup_idx); end
        tick();
        inp_valid = 4'b0010;
        inp_last  = 4'b0010;
        #1;
        checks++; if (oup_idx !== 2'd1) begin failures++; $display("FAIL wrap_skip: got %0d expected 1", oup_idx); end
        tick();
        inp_valid = 4'b1001;
        inp_last  = 4'b1001;
        #1;
        checks++; if (oup_idx !== 2'd3) begin failures++; $display("FAIL wrap_first: got %0d expected 3", oup_idx); end
        tick();
        #1;
        checks++; if (oup_idx !== 2'd0) begin failures++; $display("FAIL wrap_second: got %0d expected 0", oup_idx); end
        tick();
        inp_valid = 4'b0000;
    endtask

    // rr_ptr is 1 on entry.
    task automatic test_maxburst();
        inp_valid = 4'b0100;
        inp_last  = 4'b0000;
        for (int b = 1; b <= 5; b++) begin
            #1;
            checks++; if (oup_idx !== 2'd2) begin failures++; $display("FAIL mb_idx[%0d]: got %0d expected 2", b, oup_idx); end
            checks++; if (err !== (b >= 5)) begin failures++; $display("FAIL mb_err[%0d]: got %0b expected %0b", b, err, b >= 5); end
            tick();
        end
        checks++; if (err !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mb_sticky: err=%0b busy=%0b expected 1 1", err, busy); end
        inp_valid = 4'b0000;
        clr_i     = 1'b1;
        tick();
        clr_i = 1'b0;
        #1;
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL clr_flags: err=%0b busy=%0b expected 0 0", err, busy); end
        inp_valid = 4'b1111;
        inp_last  = 4'b1111;
        #1;
        checks++; if (oup_idx !== 2'd0) begin failures++; $display("FAIL clr_ptr: got %0d expected 0", oup_idx); end
        tick();
        #1;
        checks++; if (oup_idx !== 2'd1) begin failures++; $display("FAIL clr_next: got %0d expected 1", oup_idx); end
        tick();
        inp_valid = 4'b0000;
    endtask

    // rr_ptr is 2 on entry.
    task automatic test_async_reset();
        inp_valid = 4'b0101;
        inp_last  = 4'b0000;
        #1;
        checks++; if (oup_idx !== 2'd2) begin failures++; $display("FAIL ar_start: got %0d expected 2", oup_idx); end
        tick();
        tick();
        #1;
        checks++; if (busy !== 1'b1 || oup_idx !== 2'd2) begin failures++; $display("FAIL ar_burst: busy=%0b idx=%0d expected 1 2", busy, oup_idx); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || oup_valid !== 1'b0 || inp_ready !== 4'b0000 || oup_idx !== 2'd0 || err !== 1'b0) begin
            failures++; $display("FAIL ar_drop: busy=%0b valid=%0b ready=%b idx=%0d err=%0b expected all 0", busy, oup_valid, inp_ready, oup_idx, err);
        end
        tick();
        tick();
        rst_ni   = 1'b1;
        inp_last = 4'b0101;
        #1;
        checks++; if (oup_idx !== 2'd0 || oup_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ar_restart: idx=%0d valid=%0b busy=%0b expected 0 1 0", oup_idx, oup_valid, busy); end
        tick();
        #1;
        checks++; if (oup_idx !== 2'd2) begin failures++; $display("FAIL ar_next: got %0d expected 2", oup_idx); end
        tick();
        inp_valid = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_beats();
        test_burst_lock();
        test_backpressure();
        test_wrap_skip();
        test_maxburst();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
